// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register offsets,
// decode enum, reset constants and the byte-enable merge helper.
package bus_timer_pkg;

    localparam logic [9:0] TimerMtimeLo    = 10'h000;
    localparam logic [9:0] TimerMtimeHi    = 10'h004;
    localparam logic [9:0] TimerMtimecmpLo = 10'h008;
    localparam logic [9:0] TimerMtimecmpHi = 10'h00C;
    localparam logic [9:0] TimerPrescale   = 10'h010;
    localparam logic [9:0] TimerCtrl       = 10'h014;

    localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] PrescaleReset = 32'h0000_0000;

    typedef enum logic [2:0] {
        RegMtimeLo,
        RegMtimeHi,
        RegMtimecmpLo,
        RegMtimecmpHi,
        RegPrescale,
        RegCtrl,
        RegInvalid
    } timer_reg_e;

    // Decode works on the word index (byte address bits [9:2]).
    function automatic timer_reg_e decode_reg(input logic [7:0] word_addr);
        case (word_addr)
            TimerMtimeLo[9:2]:    return RegMtimeLo;
            TimerMtimeHi[9:2]:    return RegMtimeHi;
            TimerMtimecmpLo[9:2]: return RegMtimecmpLo;
            TimerMtimecmpHi[9:2]: return RegMtimecmpHi;
            TimerPrescale[9:2]:   return RegPrescale;
            TimerCtrl[9:2]:       return RegCtrl;
            default:              return RegInvalid;
        endcase
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler for the machine timer: counts 0..limit_i while enabled and
// pulses tick_o on the terminal count.
module bus_timer_prescaler #(
    parameter int PrescaleWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [PrescaleWidth-1:0] limit_i,
    output logic                     tick_o
);

    logic [PrescaleWidth-1:0] pcnt;

    // A clearing write restarts the period, so it also suppresses the tick.
    assign tick_o = enable_i && !clear_i && (pcnt == limit_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt <= '0;
        end else if (clear_i) begin
            pcnt <= '0;
        end else if (enable_i) begin
            pcnt <= tick_o ? '0 : pcnt + PrescaleWidth'(1);
        end
    end

endmodule

// File: rtl/bus_timer.sv
// RISC-V style mtime/mtimecmp timer on a single-cycle bus device port,
// with a prescaler and a shadowed high word for atomic 64-bit reads.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int PrescaleWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dev_req_i,
    input  logic                    dev_we_i,
    input  logic [3:0]              dev_be_i,
    input  logic [AddressWidth-1:0] dev_addr_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic                    dev_rvalid_o,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_err_o,
    output logic                    timer_irq_o
);

    logic [63:0]              mtime;
    logic [63:0]              mtimecmp;
    logic [31:0]              mtime_shadow;
    logic [PrescaleWidth-1:0] prescale;
    logic                     enable;
    logic                     tick;
    timer_reg_e               reg_sel;
    logic                     wr_en;
    logic                     rd_en;
    logic [31:0]              read_data;
    logic [31:0]              mtime_lo_wr;
    logic [31:0]              mtime_hi_wr;
    logic [31:0]              prescale_wr;
    logic                     unused_addr;

    assign reg_sel     = decode_reg(dev_addr_i[9:2]);
    assign wr_en       = dev_req_i && dev_we_i;
    assign rd_en       = dev_req_i && !dev_we_i;
    assign mtime_lo_wr = apply_be(mtime[31:0], dev_wdata_i, dev_be_i);
    assign mtime_hi_wr = apply_be(mtime[63:32], dev_wdata_i, dev_be_i);
    assign prescale_wr = apply_be(32'(prescale), dev_wdata_i, dev_be_i);
    assign unused_addr = ^{dev_addr_i[AddressWidth-1:10], dev_addr_i[1:0]};

    bus_timer_prescaler #(
        .PrescaleWidth(PrescaleWidth)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .enable_i(enable),
        .clear_i (wr_en && (reg_sel == RegPrescale)),
        .limit_i (prescale),
        .tick_o  (tick)
    );

    always_comb begin
        read_data = '0;
        case (reg_sel)
            RegMtimeLo:    read_data = mtime[31:0];
            RegMtimeHi:    read_data = mtime_shadow;
            RegMtimecmpLo: read_data = mtimecmp[31:0];
            RegMtimecmpHi: read_data = mtimecmp[63:32];
            RegPrescale:   read_data = 32'(prescale);
            RegCtrl:       read_data = {31'b0, enable};
            default:       read_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dev_rvalid_o <= 1'b0;
            dev_rdata_o  <= '0;
            dev_err_o    <= 1'b0;
        end else begin
            dev_rvalid_o <= dev_req_i;
            dev_rdata_o  <= rd_en ? read_data : '0;
            dev_err_o    <= dev_req_i && (reg_sel == RegInvalid);
        end
    end

    // A software write to either mtime half takes priority and drops that cycle's tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime        <= '0;
            mtime_shadow <= '0;
        end else begin
            if (wr_en && (reg_sel == RegMtimeLo)) begin
                mtime[31:0] <= mtime_lo_wr;
            end else if (wr_en && (reg_sel == RegMtimeHi)) begin
                mtime[63:32] <= mtime_hi_wr;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (rd_en && (reg_sel == RegMtimeLo)) begin
                mtime_shadow <= mtime[63:32];
            end else if (wr_en && (reg_sel == RegMtimeHi)) begin
                mtime_shadow <= mtime_hi_wr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtimecmp <= MtimecmpReset;
            prescale <= PrescaleReset[PrescaleWidth-1:0];
            enable   <= 1'b0;
        end else if (wr_en) begin
            case (reg_sel)
                RegMtimecmpLo: mtimecmp[31:0]  <= apply_be(mtimecmp[31:0], dev_wdata_i, dev_be_i);
                RegMtimecmpHi: mtimecmp[63:32] <= apply_be(mtimecmp[63:32], dev_wdata_i, dev_be_i);
                RegPrescale:   prescale        <= prescale_wr[PrescaleWidth-1:0];
                RegCtrl:       if (dev_be_i[0]) enable <= dev_wdata_i[0];
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_irq_o <= 1'b0;
        end else begin
            timer_irq_o <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios with literal
// expectations plus a randomized phase checked against a behavioural model.
module tb_bus_timer;

    logic        clk_i;
    logic        rst_ni;
    logic        dev_req_i;
    logic        dev_we_i;
    logic [3:0]  dev_be_i;
    logic [31:0] dev_addr_i;
    logic [31:0] dev_wdata_i;
    logic        dev_rvalid_o;
    logic [31:0] dev_rdata_o;
    logic        dev_err_o;
    logic        timer_irq_o;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    bus_timer #(
        .DataWidth    (32),
        .AddressWidth (32),
        .PrescaleWidth(8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .dev_req_i   (dev_req_i),
        .dev_we_i    (dev_we_i),
        .dev_be_i    (dev_be_i),
        .dev_addr_i  (dev_addr_i),
        .dev_wdata_i (dev_wdata_i),
        .dev_rvalid_o(dev_rvalid_o),
        .dev_rdata_o (dev_rdata_o),
        .dev_err_o   (dev_err_o),
        .timer_irq_o (timer_irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic [7:0]  m_prescale;
    logic [7:0]  m_pcnt;
    logic        m_enable;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        m_irq;

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_val & ~mask) | (wd & mask);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic is_write(input int w);
        return dev_req_i && dev_we_i && (word_of(dev_addr_i) == w);
    endfunction

    function automatic logic is_read(input int w);
        return dev_req_i && !dev_we_i && (word_of(dev_addr_i) == w);
    endfunction

    function automatic logic model_tick();
        return m_enable && (m_pcnt == m_prescale) && !is_write(4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (word_of(a))
            0:       return m_mtime[31:0];
            1:       return m_shadow;
            2:       return m_cmp[31:0];
            3:       return m_cmp[63:32];
            4:       return {24'b0, m_prescale};
            5:       return {31'b0, m_enable};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_mtime    <= 64'h0;
            m_cmp      <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_shadow   <= 32'h0;
            m_prescale <= 8'h0;
            m_pcnt     <= 8'h0;
            m_enable   <= 1'b0;
            m_rvalid   <= 1'b0;
            m_rdata    <= 32'h0;
            m_err      <= 1'b0;
            m_irq      <= 1'b0;
        end else begin
            m_rvalid <= dev_req_i;
            m_err    <= dev_req_i && (word_of(dev_addr_i) > 5);
            m_rdata  <= (dev_req_i && !dev_we_i) ? model_read(dev_addr_i) : 32'h0;
            m_irq    <= (m_mtime >= m_cmp);

            if (is_write(4))   m_pcnt <= 8'h0;
            else if (m_enable) m_pcnt <= model_tick() ? 8'h0 : m_pcnt + 8'h1;

            if (is_write(0))       m_mtime <= {m_mtime[63:32], merge(m_mtime[31:0], dev_wdata_i, dev_be_i)};
            else if (is_write(1))  m_mtime <= {merge(m_mtime[63:32], dev_wdata_i, dev_be_i), m_mtime[31:0]};
            else if (model_tick()) m_mtime <= m_mtime + 64'd1;

            if (is_read(0))       m_shadow <= m_mtime[63:32];
            else if (is_write(1)) m_shadow <= merge(m_mtime[63:32], dev_wdata_i, dev_be_i);

            if (is_write(2)) m_cmp <= {m_cmp[63:32], merge(m_cmp[31:0], dev_wdata_i, dev_be_i)};
            if (is_write(3)) m_cmp <= {merge(m_cmp[63:32], dev_wdata_i, dev_be_i), m_cmp[31:0]};
            if (is_write(4)) m_prescale <= 8'(merge({24'b0, m_prescale}, dev_wdata_i, dev_be_i));
            if (is_write(5) && dev_be_i[0]) m_enable <= dev_wdata_i[0];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && check_en) begin
            checkOutput("rvalid", 64'(dev_rvalid_o), 64'(m_rvalid));
            if (m_rvalid) begin
                checkOutput("rdata", 64'(dev_rdata_o), 64'(m_rdata));
                checkOutput("err", 64'(dev_err_o), 64'(m_err));
            end
            checkOutput("irq", 64'(timer_irq_o), 64'(m_irq));
        end
    end

    task automatic applyStimulus(input logic req, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk_i);
        dev_req_i   = req;
        dev_we_i    = we;
        dev_be_i    = be;
        dev_addr_i  = addr;
        dev_wdata_i = wdata;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        applyStimulus(1'b1, 1'b1, be, addr, data);
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data, output logic err);
        applyStimulus(1'b1, 1'b0, 4'hF, addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        data = dev_rdata_o;
        err  = dev_err_o;
    endtask

    logic [31:0] rd_data;
    logic        rd_err;
    logic [31:0] samples [17];
    logic        steps_ok;
    int          irq_cycle;
    logic [31:0] rnd_addr;
    logic [31:0] rnd_wdata;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_ni      = 1'b0;
        dev_req_i   = 1'b0;
        dev_we_i    = 1'b0;
        dev_be_i    = 4'h0;
        dev_addr_i  = 32'h0;
        dev_wdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        checkOutput("reset_rvalid", 64'(dev_rvalid_o), 64'h0);
        checkOutput("reset_rdata", 64'(dev_rdata_o), 64'h0);
        checkOutput("reset_err", 64'(dev_err_o), 64'h0);
        checkOutput("reset_irq", 64'(timer_irq_o), 64'h0);
        rst_ni   = 1'b1;
        check_en = 1'b1;

        $display("[TB] reset values of mtimecmp");
        readReg(32'h08, rd_data, rd_err);
        checkOutput("cmp_lo_reset", 64'(rd_data), 64'hFFFF_FFFF);
        checkOutput("cmp_lo_err", 64'(rd_err), 64'h0);
        readReg(32'h0C, rd_data, rd_err);
        checkOutput("cmp_hi_reset", 64'(rd_data), 64'hFFFF_FFFF);
        checkOutput("irq_after_reset", 64'(timer_irq_o), 64'h0);

        $display("[TB] byte-enable write to MTIMECMP_LO");
        writeReg(32'h08, 32'h0000_AB00, 4'b0010);
        readReg(32'h08, rd_data, rd_err);
        checkOutput("cmp_lo_be", 64'(rd_data), 64'hFFFF_ABFF);

        $display("[TB] prescale 3 counting");
        writeReg(32'h10, 32'd3, 4'hF);
        writeReg(32'h14, 32'd1, 4'hF);
        idleCycles(40);
        readReg(32'h00, rd_data, rd_err);
        checkOutput("mtime_after_40", 64'(rd_data), 64'd10);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b0, 4'hF, 32'h00, 32'h0);
            if (i > 0) samples[i-1] = dev_rdata_o;
        end
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        samples[16] = dev_rdata_o;
        steps_ok = 1'b1;
        for (int i = 1; i < 17; i++) begin
            if ((samples[i] - samples[i-1]) > 32'd1) steps_ok = 1'b0;
        end
        checkOutput("ticks_in_16_cycles", 64'(samples[16] - samples[0]), 64'd4);
        checkOutput("single_steps", 64'(steps_ok), 64'd1);

        $display("[TB] low word carry and shadow");
        writeReg(32'h14, 32'd0, 4'hF);
        writeReg(32'h00, 32'hFFFF_FFFE, 4'hF);
        writeReg(32'h04, 32'h0, 4'hF);
        writeReg(32'h10, 32'h0, 4'hF);
        writeReg(32'h14, 32'd1, 4'hF);
        idleCycles(3);
        readReg(32'h00, rd_data, rd_err);
        checkOutput("carry_lo", 64'(rd_data), 64'd1);
        readReg(32'h04, rd_data, rd_err);
        checkOutput("carry_hi_shadow", 64'(rd_data), 64'd1);

        $display("[TB] interrupt at mtimecmp = 20");
        writeReg(32'h14, 32'd0, 4'hF);
        writeReg(32'h00, 32'h0, 4'hF);
        writeReg(32'h04, 32'h0, 4'hF);
        writeReg(32'h0C, 32'h0, 4'hF);
        writeReg(32'h08, 32'd20, 4'hF);
        writeReg(32'h14, 32'd1, 4'hF);
        irq_cycle = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            if (timer_irq_o && irq_cycle == 0) irq_cycle = k;
        end
        checkOutput("irq_rise_cycle", 64'(irq_cycle), 64'd22);
        writeReg(32'h0C, 32'd1, 4'hF);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("irq_hold_one_cycle", 64'(timer_irq_o), 64'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("irq_dropped", 64'(timer_irq_o), 64'd0);

        $display("[TB] unmapped offset");
        writeReg(32'h18, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("bad_write_err", 64'(dev_err_o), 64'd1);
        readReg(32'h18, rd_data, rd_err);
        checkOutput("bad_read_err", 64'(rd_err), 64'd1);
        checkOutput("bad_read_data", 64'(rd_data), 64'd0);
        readReg(32'h10, rd_data, rd_err);
        checkOutput("prescale_untouched", 64'(rd_data), 64'd0);
        readReg(32'h0C, rd_data, rd_err);
        checkOutput("cmp_hi_untouched", 64'(rd_data), 64'd1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            rnd_addr = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2)
                     | 32'($urandom_range(0, 3));
            rnd_wdata = $urandom();
            if ($urandom_range(0, 1) == 1) rnd_wdata = 32'($urandom_range(0, 40));
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), rnd_addr, rnd_wdata);
        end

        $display("[TB] reset with a request in flight");
        writeReg(32'h0C, 32'h0, 4'hF);
        writeReg(32'h08, 32'h0, 4'hF);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h08, 32'h0);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("midreset_rvalid", 64'(dev_rvalid_o), 64'd0);
        checkOutput("midreset_irq", 64'(timer_irq_o), 64'd0);
        @(negedge clk_i);
        dev_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        readReg(32'h08, rd_data, rd_err);
        checkOutput("cmp_lo_after_reset", 64'(rd_data), 64'hFFFF_FFFF);
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
